gemm_c_drain: RTL and testbench

//  Read-side counterpart of the GEMM output path. After the accelerator has filled output SRAM C, this block reads it back.

---
 rtl/gemm_c_drain_pkg.sv | 17 +
 rtl/gemm_c_drain_c_row_buffer.sv | 58 +++++
 rtl/gemm_c_drain.sv | 127 ++++++++++++
 tb/tb_gemm_c_drain.sv | 110 +++++++++++
 4 files changed

// File: rtl/gemm_c_drain_pkg.sv
// gemm_c_drain_pkg: shared C-tile geometry, types and slicing helpers
package gemm_c_drain_pkg;
    localparam int OutDataWidth = 32;
    localparam int meshRow = 4;
    localparam int meshCol = 4;
    localparam int RowW = $clog2(meshRow);
    localparam int ColW = $clog2(meshCol);
    typedef logic [meshRow*meshCol*OutDataWidth-1:0] c_tile_t;
    typedef logic [meshCol*OutDataWidth-1:0] c_row_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic c_row_t row_of(c_tile_t t, logic [RowW-1:0] r);
        return t[int'(r)*meshCol*OutDataWidth +: meshCol*OutDataWidth];
    endfunction
    function automatic logic [OutDataWidth-1:0] elem_of(c_row_t row, logic [ColW-1:0] c);
        return row[int'(c)*OutDataWidth +: OutDataWidth];
    endfunction
endpackage

// File: rtl/gemm_c_drain_c_row_buffer.sv
// c_row_buffer: two-slot ping-pong of tile row slices, drained one element per handshake
module c_row_buffer
    import gemm_c_drain_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wr_en_i,
    input  logic [meshCol*OutDataWidth-1:0] wr_row_i,
    input  logic                    wr_row_last_i,
    input  logic                    wr_last_i,
    input  logic                    ready_i,
    output logic [OutDataWidth-1:0] data_o,
    output logic                    valid_o,
    output logic                    row_last_o,
    output logic                    last_o,
    output logic                    slice_done_o
);
    c_row_t          row_q [2];
    logic [1:0]      vld_q, rl_q, l_q;
    logic            wr_ptr_q, rd_ptr_q;
    logic [ColW-1:0] col_q;
    logic            col_end;
    // present the current element of the draining slot; flags only on its final column
    always_comb begin
        col_end      = col_q == ColW'(meshCol - 1);
        valid_o      = vld_q[rd_ptr_q];
        data_o       = elem_of(row_q[rd_ptr_q], col_q);
        row_last_o   = valid_o && col_end && rl_q[rd_ptr_q];
        last_o       = valid_o && col_end && l_q[rd_ptr_q];
        slice_done_o = valid_o && ready_i && col_end;
    end
    // slot fill from the read pipe and drain on handshakes; writes only ever target a free slot
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_q[0] <= '0;
            row_q[1] <= '0;
            vld_q    <= '0;
            rl_q     <= '0;
            l_q      <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            col_q    <= '0;
        end else begin
            if (valid_o && ready_i) col_q <= col_end ? '0 : col_q + ColW'(1);
            if (slice_done_o) begin
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= ~rd_ptr_q;
            end
            if (wr_en_i) begin
                row_q[wr_ptr_q] <= wr_row_i;
                vld_q[wr_ptr_q] <= 1'b1;
                rl_q[wr_ptr_q]  <= wr_row_last_i;
                l_q[wr_ptr_q]   <= wr_last_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
        end
    end
endmodule

// File: rtl/gemm_c_drain.sv
// gemm_c_drain: reads packed C tiles back from SRAM and streams the matrix in global row-major order
module gemm_c_drain
    import gemm_c_drain_pkg::*;
#(
    parameter int DataDepth     = 4096,
    parameter int AddrWidth     = $clog2(DataDepth),
    parameter int SizeAddrWidth = 8
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   start_i,
    input  logic [SizeAddrWidth-1:0]               M_size_i,
    input  logic [SizeAddrWidth-1:0]               N_size_i,
    output logic [AddrWidth-1:0]                   sram_c_addr_o,
    input  logic [meshRow*meshCol*OutDataWidth-1:0] sram_c_rdata_i,
    output logic [OutDataWidth-1:0]                data_o,
    output logic                                   valid_o,
    input  logic                                   ready_i,
    output logic                                   row_last_o,
    output logic                                   last_o,
    output logic                                   busy_o,
    output logic                                   done_o
);
    state_t                   state_q, state_d;
    logic [SizeAddrWidth-1:0] m_sz_q, n_sz_q, m_sz, n_sz;
    logic [SizeAddrWidth-1:0] m_q, m_d, n_q, n_d;
    logic [RowW-1:0]          r_q, r_d, iss_r_q, rd_r_q;
    logic [AddrWidth-1:0]     base_q, base_d, addr_q, addr_d;
    logic [1:0]               cnt_q, cnt_d;
    logic                     all_iss_q, all_iss_d;
    logic                     iss_q, iss_rl_q, iss_l_q, rd_q, rd_rl_q, rd_l_q;
    logic                     start_ok, issue, n_end, r_end, m_end, wrap, slice_done;
    assign sram_c_addr_o = addr_q;
    c_row_buffer u_buf (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .wr_en_i      (rd_q),
        .wr_row_i     (row_of(sram_c_rdata_i, rd_r_q)),
        .wr_row_last_i(rd_rl_q),
        .wr_last_i    (rd_l_q),
        .ready_i      (ready_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .row_last_o   (row_last_o),
        .last_o       (last_o),
        .slice_done_o (slice_done)
    );
    // traversal counters and read issue; cnt tracks filled slots plus reads still in flight
    always_comb begin
        start_ok  = state_q == IDLE && start_i;
        m_sz      = start_ok ? M_size_i : m_sz_q;
        n_sz      = start_ok ? N_size_i : n_sz_q;
        issue     = start_ok ? (M_size_i != '0 && N_size_i != '0)
                             : (state_q == RUN && !all_iss_q && (cnt_q != 2'd2 || slice_done));
        n_end     = n_q == n_sz - SizeAddrWidth'(1);
        r_end     = r_q == RowW'(meshRow - 1);
        m_end     = m_q == m_sz - SizeAddrWidth'(1);
        wrap      = n_end && r_end;
        n_d       = issue ? (n_end ? '0 : n_q + SizeAddrWidth'(1)) : n_q;
        r_d       = issue && n_end ? (r_end ? '0 : r_q + RowW'(1)) : r_q;
        m_d       = issue && wrap ? (m_end ? '0 : m_q + SizeAddrWidth'(1)) : m_q;
        base_d    = issue && wrap ? (m_end ? '0 : base_q + AddrWidth'(n_sz)) : base_q;
        addr_d    = issue ? base_q + AddrWidth'(n_q) : addr_q;
        all_iss_d = (all_iss_q && !start_ok) || (issue && wrap && m_end);
        cnt_d     = cnt_q + 2'(issue) - 2'(slice_done);
    end
    // datapath registers: counters, address and the two-stage read tag pipe matching SRAM latency
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_sz_q    <= '0;
            n_sz_q    <= '0;
            m_q       <= '0;
            n_q       <= '0;
            r_q       <= '0;
            base_q    <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            all_iss_q <= 1'b0;
            iss_q     <= 1'b0;
            iss_rl_q  <= 1'b0;
            iss_l_q   <= 1'b0;
            iss_r_q   <= '0;
            rd_q      <= 1'b0;
            rd_rl_q   <= 1'b0;
            rd_l_q    <= 1'b0;
            rd_r_q    <= '0;
        end else begin
            m_sz_q    <= m_sz;
            n_sz_q    <= n_sz;
            m_q       <= m_d;
            n_q       <= n_d;
            r_q       <= r_d;
            base_q    <= base_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            all_iss_q <= all_iss_d;
            iss_q     <= issue;
            iss_rl_q  <= n_end;
            iss_l_q   <= wrap && m_end;
            iss_r_q   <= r_q;
            rd_q      <= iss_q;
            rd_rl_q   <= iss_rl_q;
            rd_l_q    <= iss_l_q;
            rd_r_q    <= iss_r_q;
        end
    end
    // state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end
    // next state: empty matrix skips straight to DONE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = (M_size_i == '0 || N_size_i == '0) ? DONE : RUN;
            RUN:     if (valid_o && ready_i && last_o) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // status outputs
    always_comb begin
        busy_o = state_q == RUN;
        done_o = state_q == DONE;
    end
endmodule

// File: tb/tb_gemm_c_drain.sv
// tb_gemm_c_drain: directed checks of the C drain stream against a row-major unpack model
module tb_gemm_c_drain;
    localparam int W = 32, R = 4, C = 4, AW = 12;
    logic              clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0, ready_i = 1'b0;
    logic [7:0]        M_size_i = '0, N_size_i = '0;
    logic [AW-1:0]     sram_c_addr_o;
    logic [R*C*W-1:0]  sram_c_rdata_i;
    logic [W-1:0]      data_o;
    logic              valid_o, row_last_o, last_o, busy_o, done_o;
    logic [R*C*W-1:0]  mem [64];
    int                n_asserts = 0, n_fail = 0;

    gemm_c_drain dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .M_size_i(M_size_i), .N_size_i(N_size_i),
        .sram_c_addr_o(sram_c_addr_o), .sram_c_rdata_i(sram_c_rdata_i),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .row_last_o(row_last_o), .last_o(last_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) sram_c_rdata_i <= mem[sram_c_addr_o[5:0]];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int m, input int n, input bit rnd, input int abort_at, input int poke_at);
        int total, idx, cyc, first, gaps, done_cyc, last_cyc, ec, en, er, em;
        bit held, rdy, exp_rl, exp_l;
        logic [W+1:0] held_v;
        total = m * n * R * C;
        idx = 0; cyc = 0; first = -1; gaps = 0; done_cyc = -1; last_cyc = -1; held = 0;
        held_v = '0;
        M_size_i = 8'(m); N_size_i = 8'(n); start_i = 1'b1; ready_i = !rnd;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        check("busy_after_start", busy_o, total > 0);
        while (cyc < 2000) begin
            start_i = 1'b0;
            if (cyc == abort_at) begin
                rst_ni = 1'b0; #1;
                check("abort_outputs", {sram_c_addr_o, data_o, valid_o, row_last_o, last_o, busy_o, done_o}, '0);
                #2 rst_ni = 1'b1;
                @(posedge clk_i); #1;
                return;
            end
            if (done_o) begin
                done_cyc = cyc;
                break;
            end
            if (held) check("hold_stable", {valid_o, data_o, row_last_o, last_o}, {1'b1, held_v});
            held = 0;
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (idx >= total) check("no_extra_valid", valid_o, 1'b0);
            else if (valid_o) begin
                if (first < 0) first = cyc;
                if (rdy) begin
                    ec = idx % C; en = (idx / C) % n; er = (idx / (C * n)) % R; em = idx / (R * C * n);
                    exp_rl = en == n - 1 && ec == C - 1;
                    exp_l  = exp_rl && em == m - 1 && er == R - 1;
                    check("element", {data_o, row_last_o, last_o}, {32'((em * n + en) * 100 + er * C + ec), exp_rl, exp_l});
                    idx++;
                    last_cyc = cyc;
                end else begin
                    held = 1;
                    held_v = {data_o, row_last_o, last_o};
                end
            end else if (first >= 0) gaps++;
            if (cyc == poke_at) begin
                start_i = 1'b1; M_size_i = 8'd1; N_size_i = 8'd1;
            end
            ready_i = rdy;
            @(posedge clk_i); #1;
            cyc++;
        end
        check("element_count", idx, total);
        check("done_timing", done_cyc, total > 0 ? last_cyc + 1 : 0);
        if (!rnd && total > 0) begin
            check("first_valid_cycle", first, 2);
            check("valid_gaps", gaps, 0);
        end
        @(posedge clk_i); #1;
        check("done_one_cycle", {done_o, busy_o, valid_o}, 3'b000);
    endtask

    initial begin
        for (int w = 0; w < 64; w++)
            for (int k = 0; k < R * C; k++)
                mem[w][k*W +: W] = 32'(w * 100 + k);
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_outputs", {sram_c_addr_o, data_o, valid_o, row_last_o, last_o, busy_o, done_o}, '0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        run(1, 1, 0, -1, -1);
        run(1, 2, 0, -1, -1);
        run(8, 8, 0, -1, -1);
        run(2, 3, 1, -1, 20);
        run(0, 5, 0, -1, -1);
        run(8, 8, 0, 100, -1);
        run(8, 8, 0, -1, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
